// File: rtl/ysyx_23060208_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter, one transaction at a time.
// Define YSYX_23060208_ARB_RR_EN for round-robin between masters; otherwise fixed LSU-first priority.
module ysyx_23060208_axi_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    // Master 0: IFU, read only
    input  logic [DATA_WIDTH-1:0] m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,

    // Master 1: LSU, read and write
    input  logic [DATA_WIDTH-1:0] m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [DATA_WIDTH-1:0] m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [STRB_WIDTH-1:0] m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [1:0]            m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,

    // Shared slave port
    output logic [DATA_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [DATA_WIDTH-1:0] s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic [STRB_WIDTH-1:0] s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready,

    output logic                  arb_busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRdM0 = 2'd1,
        StRdM1 = 2'd2,
        StWrM1 = 2'd3
    } state_e;

    state_e r_state;
    state_e w_state_next;
    state_e w_grant_state;
    state_e w_m1_state;

    logic r_ar_done;
    logic r_aw_done;
    logic r_w_done;

    logic w_ar_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_r_hs;
    logic w_b_hs;
    logic w_leave;
    logic w_m1_req;

    assign w_ar_hs  = s_arvalid && s_arready;
    assign w_aw_hs  = s_awvalid && s_awready;
    assign w_w_hs   = s_wvalid && s_wready;
    assign w_r_hs   = s_rvalid && s_rready;
    assign w_b_hs   = s_bvalid && s_bready;
    assign w_leave  = (r_state != StIdle) && (w_state_next == StIdle);
    assign arb_busy = (r_state != StIdle);

    // LSU reads always go ahead of LSU writes.
    assign w_m1_req   = m1_arvalid || m1_awvalid;
    assign w_m1_state = m1_arvalid ? StRdM1 : StWrM1;

`ifdef YSYX_23060208_ARB_RR_EN
    // 1 means the LSU held the port last; 0 means the IFU did.
    logic r_last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b0;
        end else if (w_leave) begin
            r_last_grant <= (r_state != StRdM0);
        end
    end

    always_comb begin
        w_grant_state = StIdle;
        if (w_m1_req && m0_arvalid) begin
            w_grant_state = r_last_grant ? StRdM0 : w_m1_state;
        end else if (w_m1_req) begin
            w_grant_state = w_m1_state;
        end else if (m0_arvalid) begin
            w_grant_state = StRdM0;
        end
    end
`else
    always_comb begin
        w_grant_state = StIdle;
        if (w_m1_req) begin
            w_grant_state = w_m1_state;
        end else if (m0_arvalid) begin
            w_grant_state = StRdM0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_leave) begin
                r_ar_done <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_ar_hs) r_ar_done <= 1'b1;
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:         w_state_next = w_grant_state;
            StRdM0, StRdM1: if (w_r_hs) w_state_next = StIdle;
            StWrM1:         if (w_b_hs) w_state_next = StIdle;
            default:        w_state_next = StIdle;
        endcase
    end

    always_comb begin
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = 2'b00;
        m1_bvalid  = 1'b0;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        case (r_state)
            StRdM0: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid && !r_ar_done;
                m0_arready = s_arready && !r_ar_done;
                s_rready   = m0_rready;
                m0_rvalid  = s_rvalid;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
            end
            StRdM1: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid && !r_ar_done;
                m1_arready = s_arready && !r_ar_done;
                s_rready   = m1_rready;
                m1_rvalid  = s_rvalid;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
            end
            StWrM1: begin
                // AW and W complete independently, in either order.
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid && !r_aw_done;
                m1_awready = s_awready && !r_aw_done;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid && !r_w_done;
                m1_wready  = s_wready && !r_w_done;
                s_bready   = m1_bready;
                m1_bvalid  = s_bvalid;
                m1_bresp   = s_bresp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_axi_arbiter.sv
// Directed bench for the AXI4-Lite arbiter; the bench acts as both masters and the slave.
module tb_ysyx_23060208_axi_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata;
    logic          m0_arvalid, m0_rready, m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready;
    logic [SW-1:0] m1_wstrb;
    logic          s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [1:0]    s_rresp, s_bresp;

    logic          m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
    logic [DW-1:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
    logic [1:0]    m0_rresp, m1_rresp, m1_bresp;
    logic          s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, arb_busy;
    logic [SW-1:0] s_wstrb;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_23060208_axi_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .arb_busy(arb_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0;
        m1_bready = 0;
        s_arready = 0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 0;
        s_awready = 0; s_wready = 0; s_bresp = 2'b00; s_bvalid = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        n_chk++;
        if (arb_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %0b want 0", arb_busy);
        end
        n_chk++;
        if ({m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}
            !== 7'b0) begin
            n_err++; $display("FAIL reset_master_outs: got %b want 0000000",
                {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid});
        end
        n_chk++;
        if ({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 5'b0) begin
            n_err++; $display("FAIL reset_slave_outs: got %b want 00000",
                {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready});
        end
        // A request while reset is held must not be granted.
        m1_arvalid = 1'b1;
        tick();
        n_chk++;
        if (arb_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_hold_grant: got busy=%0b want 0", arb_busy);
        end
        rst = 1'b0;
        m1_arvalid = 1'b0;
        tick();
    endtask

    task automatic test_ifu_read();
        m0_araddr = 32'h8000_0000; m0_arvalid = 1; m0_rready = 1;
        #1;
        n_chk++;
        if ({arb_busy, s_arvalid} !== 2'b00) begin
            n_err++; $display("FAIL ifu_arb_latency: got %b want 00", {arb_busy, s_arvalid});
        end
        tick();
        n_chk++;
        if ({s_arvalid, s_araddr, m0_arready} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            n_err++; $display("FAIL ifu_ar_fwd: got v=%0b a=%h rdy=%0b want 1 80000000 0",
                s_arvalid, s_araddr, m0_arready);
        end
        tick();
        s_arready = 1;
        #1;
        n_chk++;
        if (m0_arready !== 1'b1) begin
            n_err++; $display("FAIL ifu_arready: got %0b want 1", m0_arready);
        end
        tick();
        // AR already accepted: a lingering valid must not be re-forwarded.
        #1;
        n_chk++;
        if ({s_arvalid, m0_arready} !== 2'b00) begin
            n_err++; $display("FAIL ifu_ar_done: got %b want 00", {s_arvalid, m0_arready});
        end
        m0_arvalid = 0; s_arready = 0;
        tick();
        tick();
        s_rvalid = 1; s_rdata = 32'h0000_0413; s_rresp = 2'b00;
        #1;
        n_chk++;
        if ({m0_rvalid, m0_rdata, m0_rresp, s_rready} !== {1'b1, 32'h0000_0413, 2'b00, 1'b1}) begin
            n_err++; $display("FAIL ifu_r: got v=%0b d=%h resp=%0d rr=%0b want 1 00000413 0 1",
                m0_rvalid, m0_rdata, m0_rresp, s_rready);
        end
        n_chk++;
        if ({m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid, s_awvalid, s_wvalid}
            !== 7'b0) begin
            n_err++; $display("FAIL ifu_lsu_quiet: got %b want 0000000",
                {m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid, s_awvalid, s_wvalid});
        end
        tick();
        clear_inputs();
        #1;
        n_chk++;
        if (arb_busy !== 1'b0) begin
            n_err++; $display("FAIL ifu_idle: got busy=%0b want 0", arb_busy);
        end
    endtask

    task automatic test_tie();
        m0_araddr = 32'h8000_0004; m0_arvalid = 1; m0_rready = 1;
        m1_araddr = 32'h8000_1000; m1_arvalid = 1; m1_rready = 1;
        tick();
        s_arready = 1;
        #1;
        n_chk++;
        if ({s_araddr, m1_arready, m0_arready} !== {32'h8000_1000, 2'b10}) begin
            n_err++; $display("FAIL tie_m1_first: got a=%h rdy1=%0b rdy0=%0b want 80001000 1 0",
                s_araddr, m1_arready, m0_arready);
        end
        tick();
        m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h1111_1111;
        #1;
        n_chk++;
        if ({m0_rvalid, m1_rvalid, m1_rdata} !== {2'b01, 32'h1111_1111}) begin
            n_err++; $display("FAIL tie_m1_r: got v0=%0b v1=%0b d=%h want 0 1 11111111",
                m0_rvalid, m1_rvalid, m1_rdata);
        end
        tick();
        s_rvalid = 0;
        #1;
        n_chk++;
        if (arb_busy !== 1'b0) begin
            n_err++; $display("FAIL tie_gap: got busy=%0b want 0", arb_busy);
        end
        tick();
        s_arready = 1;
        #1;
        n_chk++;
        if ({s_arvalid, s_araddr, m0_arready} !== {1'b1, 32'h8000_0004, 1'b1}) begin
            n_err++; $display("FAIL tie_m0_next: got v=%0b a=%h rdy=%0b want 1 80000004 1",
                s_arvalid, s_araddr, m0_arready);
        end
        tick();
        m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h2222_2222;
        #1;
        n_chk++;
        if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 32'h2222_2222}) begin
            n_err++; $display("FAIL tie_m0_r: got v0=%0b v1=%0b d=%h want 1 0 22222222",
                m0_rvalid, m1_rvalid, m0_rdata);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_write();
        m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wvalid = 1; m1_bready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if ({arb_busy, m1_wready, s_wvalid} !== 3'b000) begin
                n_err++; $display("FAIL wr_w_early[%0d]: got %b want 000", i,
                    {arb_busy, m1_wready, s_wvalid});
            end
            tick();
        end
        m1_awaddr = 32'h8000_2000; m1_awvalid = 1;
        tick();
        s_wready = 1;
        #1;
        n_chk++;
        if ({s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb}
            !== {1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
            n_err++; $display("FAIL wr_fwd: got awv=%0b aw=%h wv=%0b wd=%h ws=%h want 1 80002000 1 deadbeef f",
                s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb);
        end
        n_chk++;
        if ({m1_wready, m1_awready, s_arvalid} !== 3'b100) begin
            n_err++; $display("FAIL wr_w_first: got %b want 100", {m1_wready, m1_awready, s_arvalid});
        end
        tick();
        s_awready = 1;
        #1;
        n_chk++;
        if ({s_wvalid, m1_wready, s_awvalid, m1_awready} !== 4'b0011) begin
            n_err++; $display("FAIL wr_w_done: got %b want 0011",
                {s_wvalid, m1_wready, s_awvalid, m1_awready});
        end
        tick();
        m1_wvalid = 0; m1_awvalid = 0; s_awready = 0; s_wready = 0;
        #1;
        n_chk++;
        if ({s_awvalid, s_wvalid, m1_bvalid, arb_busy} !== 4'b0001) begin
            n_err++; $display("FAIL wr_b_wait: got %b want 0001",
                {s_awvalid, s_wvalid, m1_bvalid, arb_busy});
        end
        tick();
        s_bvalid = 1; s_bresp = 2'b00;
        #1;
        n_chk++;
        if ({m1_bvalid, m1_bresp, s_bready, s_arvalid} !== 5'b10010) begin
            n_err++; $display("FAIL wr_b: got %b want 10010", {m1_bvalid, m1_bresp, s_bready, s_arvalid});
        end
        tick();
        clear_inputs();
        #1;
        n_chk++;
        if (arb_busy !== 1'b0) begin
            n_err++; $display("FAIL wr_idle: got busy=%0b want 0", arb_busy);
        end
        tick();
    endtask

    task automatic test_rresp();
        m0_araddr = 32'h8000_0008; m0_arvalid = 1; m0_rready = 1;
        tick();
        s_arready = 1;
        tick();
        m0_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rresp = 2'b10; s_rdata = 32'h0BAD_0BAD;
        #1;
        n_chk++;
        if ({m0_rvalid, m0_rresp} !== 3'b110) begin
            n_err++; $display("FAIL rresp_slverr: got v=%0b resp=%b want 1 10", m0_rvalid, m0_rresp);
        end
        tick();
        clear_inputs();
        m1_araddr = 32'h8000_1004; m1_arvalid = 1; m1_rready = 1;
        tick();
        #1;
        n_chk++;
        if ({arb_busy, s_arvalid, s_araddr} !== {2'b11, 32'h8000_1004}) begin
            n_err++; $display("FAIL rresp_next_arb: got busy=%0b v=%0b a=%h want 1 1 80001004",
                arb_busy, s_arvalid, s_araddr);
        end
        s_arready = 1;
        tick();
        m1_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rresp = 2'b11;
        #1;
        n_chk++;
        if ({m1_rvalid, m1_rresp} !== 3'b111) begin
            n_err++; $display("FAIL rresp_decerr: got v=%0b resp=%b want 1 11", m1_rvalid, m1_rresp);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        m1_araddr = 32'h8000_1008; m1_arvalid = 1; m1_rready = 1;
        tick();
        s_arready = 1;
        tick();
        m1_arvalid = 0; s_arready = 0;
        #1;
        n_chk++;
        if (arb_busy !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_pre: got busy=%0b want 1", arb_busy);
        end
        rst = 1;
        tick();
        s_rvalid = 1; s_rdata = 32'h5555_5555;
        #1;
        n_chk++;
        if (arb_busy !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_idle: got busy=%0b want 0", arb_busy);
        end
        n_chk++;
        if ({m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
             s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 12'b0) begin
            n_err++; $display("FAIL rst_mid_outs: got %b want all zero",
                {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
                 s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready});
        end
        rst = 0;
        tick();
        #1;
        n_chk++;
        if ({m1_rvalid, s_rready} !== 2'b00) begin
            n_err++; $display("FAIL rst_stray_r: got %b want 00", {m1_rvalid, s_rready});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int   m0_grants = 0;
        int   m0_expect;
        logic exp_m0;
        logic [DW-1:0] exp_addr;
`ifdef YSYX_23060208_ARB_RR_EN
        m0_expect = 2;
`else
        m0_expect = 0;
`endif
        m0_araddr = 32'h8000_0100; m0_arvalid = 1; m0_rready = 1;
        m1_araddr = 32'h8000_3000; m1_arvalid = 1; m1_rready = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_23060208_ARB_RR_EN
            exp_m0 = (i % 2) == 1;
`else
            exp_m0 = 1'b0;
`endif
            exp_addr = exp_m0 ? 32'h8000_0100 : 32'h8000_3000;
            tick();
            s_arready = 1;
            #1;
            n_chk++;
            if ({arb_busy, s_araddr} !== {1'b1, exp_addr}) begin
                n_err++; $display("FAIL b2b_grant[%0d]: got busy=%0b a=%h want 1 %h", i,
                    arb_busy, s_araddr, exp_addr);
            end
            if (m0_arready === 1'b1) m0_grants++;
            tick();
            s_arready = 0; s_rvalid = 1; s_rdata = i;
            #1;
            n_chk++;
            if ({m0_rvalid, m1_rvalid} !== {exp_m0, !exp_m0}) begin
                n_err++; $display("FAIL b2b_r[%0d]: got v0=%0b v1=%0b want %0b %0b", i,
                    m0_rvalid, m1_rvalid, exp_m0, !exp_m0);
            end
            tick();
            s_rvalid = 0;
            #1;
            n_chk++;
            if (arb_busy !== 1'b0) begin
                n_err++; $display("FAIL b2b_gap[%0d]: got busy=%0b want 0", i, arb_busy);
            end
        end
        n_chk++;
        if (m0_grants !== m0_expect) begin
            n_err++; $display("FAIL b2b_m0_count: got %0d want %0d", m0_grants, m0_expect);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_tie();
        test_write();
        test_rresp();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_axi_arbiter.md
Name: ysyx_23060208_axi_arbiter

Overview:
- Two-master, one-slave AXI4-Lite arbiter.
- Shares the single memory slave port between the IFU (master 0, read-only) and the LSU (master 1, read/write).
- Sits between the IFU/LSU bus interfaces and the SRAM model.
- Grants one complete transaction at a time and routes all channels to the granted master.

Parameters:
- DATA_WIDTH, 32, width of address and data buses.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- m0_araddr  input  DATA_WIDTH  IFU read address
- m0_arvalid / m0_arready  input/output  1  IFU AR handshake
- m0_rdata  output  DATA_WIDTH  IFU read data
- m0_rresp  output  2  IFU read response
- m0_rvalid / m0_rready  output/input  1  IFU R handshake
- m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_rready: LSU read channels; same directions and widths as the m0 set
- m1_awaddr  input  DATA_WIDTH  LSU write address
- m1_awvalid / m1_awready  input/output  1
- m1_wdata  input  DATA_WIDTH
- m1_wstrb  input  STRB_WIDTH
- m1_wvalid / m1_wready  input/output  1
- m1_bresp  output  2
- m1_bvalid / m1_bready  output/input  1
- s_araddr, s_arvalid, s_arready, s_rdata, s_rresp, s_rvalid, s_rready: slave read channels; directions mirror the master side
- s_awaddr, s_awvalid, s_awready, s_wdata, s_wstrb, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready: slave write channels; directions mirror the master side
- arb_busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, RD_M0, RD_M1, WR_M1. Registered state; reset to IDLE.
- IDLE: all master-side ready/valid outputs = 0; all slave-side valid/ready outputs = 0.
  - Sample requests m0_arvalid, m1_arvalid, m1_awvalid.
  - Fixed priority: m1 read > m1 write > m0 read.
  - Next state is the winner's state. Grant is visible on the slave port the cycle after the request is seen (1-cycle arbitration latency).
- RD_Mx:
  - s_araddr = mx_araddr.
  - s_arvalid = mx_arvalid && !ar_done; mx_arready = s_arready && !ar_done.
  - ar_done is set on the AR handshake and cleared on leaving the state.
  - s_rready = mx_rready; mx_rvalid/rdata/rresp forwarded from slave.
  - On s_rvalid && s_rready: return to IDLE next cycle.
- WR_M1:
  - AW and W forwarded independently, gated by aw_done and w_done. Either order is accepted, including the same cycle.
  - s_bready = m1_bready; B channel forwarded.
  - On B handshake: return to IDLE; aw_done and w_done cleared.
- Non-granted master: all its ready/valid outputs held 0. Its pending valid stays pending; masters must hold valid and payload stable until ready (AXI rule).
- Responses (rresp/bresp, including SLVERR/DECERR) pass through unmodified. The arbiter generates no responses.
- Exactly one outstanding transaction; no interleaving.
- Back-to-back transactions: minimum of 1 IDLE cycle between them.
- Simultaneous events: if m0_arvalid and m1_arvalid rise in the same cycle, m1 wins and m0 waits. m0 is served in the IDLE that follows m1's R handshake, unless m1 re-requests (see Optional Feature).
- Reset mid-transaction: state -> IDLE, done flags -> 0, all outputs return to their idle values next cycle. The slave must be reset concurrently; stray responses after reset are not forwarded.
- arb_busy: 0 on reset.

Optional Feature:
- Macro: YSYX_23060208_ARB_RR_EN.
- Defined:
  - Round-robin between masters using a 1-bit last_grant register, reset 0 (meaning m0 last served, so m1 wins the first tie).
  - On a tie, the master not last granted wins. last_grant updates when leaving RD_M0/RD_M1/WR_M1.
  - m1 internal read-before-write order is unchanged.
- Undefined: fixed priority as specified in Behaviour; m0 may starve under continuous LSU traffic.

Test Plan:
- IFU only: m0 read 0x80000000, slave returns 0x00000413 with 1-cycle AR and 2-cycle R latency -> m0_rdata = 0x00000413, rresp = 0, state returns to IDLE; LSU outputs stay 0 throughout.
- Simultaneous m0 read 0x80000004 and m1 read 0x80001000 -> m1 served first, then m0. With RR enabled and a repeated tie, the next winner alternates.
- LSU write addr 0x80002000, data 0xDEADBEEF, wstrb 0xF, with W presented 3 cycles before AW -> the slave sees both; m1_bvalid is forwarded with bresp = 0; no AR issued during the write.
- Slave returns rresp = 2'b10 on an m0 read -> m0_rresp = 2'b10 unchanged; the next request is arbitrated normally.
- Assert rst while in RD_M1 after the AR handshake -> next cycle state = IDLE, arb_busy = 0, all valid/ready outputs = 0.
- Hold m1_arvalid continuously with m0 pending -> without RR, m0 never granted; with RR, m0 granted every second transaction.
